// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO for audio sample streams.
//
// Sits between sample producers (ADC/I2S capture) and effect-processing
// stages. Full/empty are derived from a registered fill counter, so pointer
// equality is never used to tell full from empty.
//
// Parameters:
//   DATA_W   - data word width (>= 1)
//   ADDR_W   - address width, DEPTH = 2**ADDR_W (>= 2)
//   AF_LEVEL - almost-full when fill_count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL - almost-empty when fill_count <= AE_LEVEL (0..DEPTH-1)
//
// Ports:
//   clk, rst_n         - clock (rising edge), async active-low reset
//   wr, data_in        - write request and write data
//   rd                 - read request
//   flush              - synchronous clear of contents, flags and data_out
//   err_clr            - synchronous clear of the sticky error flags
//   data_out           - read data
//   fifo_full/empty    - fill_count == DEPTH / fill_count == 0
//   fifo_almost_full   - fill_count >= AF_LEVEL
//   fifo_almost_empty  - fill_count <= AE_LEVEL
//   fill_count         - words stored, 0..DEPTH
//   fifo_overflow      - sticky: a write was rejected
//   fifo_underflow     - sticky: a read was rejected
//
// Build option:
//   FIFO_FWFT_EN - when defined, first-word-fall-through read: data_out shows
//                  the head word combinationally (0 when empty). When
//                  undefined, data_out is registered with one-cycle latency.

module sync_fifo_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  input  logic              flush,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_almost_full,
  output logic              fifo_almost_empty,
  output logic [ADDR_W:0]   fill_count,
  output logic              fifo_overflow,
  output logic              fifo_underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wr_ok, rd_ok;

  // Status decodes of the registered count: glitch-free relative to clk.
  assign fifo_full         = (count_q == CNT_W'(DEPTH));
  assign fifo_empty        = (count_q == '0);
  assign fifo_almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign fifo_almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign fill_count        = count_q;
  assign fifo_overflow     = ovf_q;
  assign fifo_underflow    = udf_q;

  // Acceptance uses the flags as they stand at the edge; flush suppresses both.
  assign wr_ok = wr & ~fifo_full  & ~flush;
  assign rd_ok = rd & ~fifo_empty & ~flush;

  // Pointer and counter next state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + ADDR_W'(1);
      if (rd_ok) rptr_d = rptr_q + ADDR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Sticky error flags: a new rejection wins over err_clr in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (flush) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      ovf_d = (wr & fifo_full)  | (ovf_q & ~err_clr);
      udf_d = (rd & fifo_empty) | (udf_q & ~err_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array; contents survive flush and reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  // Head word falls through; forced to zero so an empty FIFO shows no stale data.
  assign data_out = fifo_empty ? '0 : mem_q[rptr_q];
`else
  logic [DATA_W-1:0] dout_q, dout_d;

  // Registered read port: loads on an accepted read, holds otherwise.
  always_comb begin
    dout_d = dout_q;
    if (flush)      dout_d = '0;
    else if (rd_ok) dout_d = mem_q[rptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_q <= '0;
    else        dout_q <= dout_d;
  end

  assign data_out = dout_q;
`endif

endmodule
